uart_tx_drain: RTL and testbench

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

---
 rtl/uart_pkg.sv | 5 +
 rtl/baud_tick.sv | 22 ++
 rtl/uart_tx_drain.sv | 68 ++++++
 tb/tb_uart_tx_drain.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and default bit period for the UART transmit drain
package uart_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tx_state_t;
  localparam int CLKS_PER_BIT_DEFAULT = 868;
endpackage

// File: rtl/baud_tick.sv
// baud_tick: counts 0..CLKS_PER_BIT-1 and pulses tick_out at the terminal count
module baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clear_in,
  output logic tick_out
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_out = cnt_q == LAST;
    cnt_d = (clear_in || tick_out) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pulls bytes from an upstream FIFO and sends each one 8N1, LSB first
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       enable_in,
  input  logic [7:0] fifo_data_in,
  input  logic       fifo_empty_in,
  output logic       fifo_dequeue_out,
  output logic       tx_out,
  output logic       busy_out,
  output logic       done_out
);
  tx_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic tx_q, tx_d, tick, baud_clear;
  assign baud_clear = state_q == IDLE || state_q == LOAD;
  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear_in (baud_clear),
    .tick_out (tick)
  );
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE:  state_d = fifo_dequeue_out ? LOAD : IDLE;
      LOAD: begin
        state_d = START;
        shift_d = fifo_data_in;
      end
      START: state_d = tick ? DATA : START;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP:  state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
    // line level is registered, so it is derived from where the FSM is heading
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_comb begin
    fifo_dequeue_out = rst_n_in && state_q == IDLE && enable_in && !fifo_empty_in;
    busy_out = state_q != IDLE || fifo_dequeue_out;
    done_out = state_q == STOP && tick;
    tx_out = tx_q;
  end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: random and directed stimulus against a frame-timeline model of the drain
module tb_uart_tx_drain;
  localparam int N = 4;
  localparam int LAST = 2 + 10 * N - 1;
  logic clk_in = 1'b0, rst_n_in = 1'b0, enable_in = 1'b0, fifo_empty_in = 1'b1;
  logic [7:0] fifo_data_in = 8'h00;
  logic fifo_dequeue_out, tx_out, busy_out, done_out;
  int checks = 0, errors = 0;
  byte unsigned q[$];
  int t = -1, k, deq_cnt, done_cnt, busy_cnt, lo_cnt, gap_n, last_gap;
  logic [7:0] mb;
  logic e_tx, pend = 1'b0, gap_on = 1'b0;
  logic [9:0] samp;

  uart_tx_drain #(.CLKS_PER_BIT(N)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .enable_in        (enable_in),
    .fifo_data_in     (fifo_data_in),
    .fifo_empty_in    (fifo_empty_in),
    .fifo_dequeue_out (fifo_dequeue_out),
    .tx_out           (tx_out),
    .busy_out         (busy_out),
    .done_out         (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(string nm, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, a, e);
    end
  endtask

  task automatic lit(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, a, e);
    end
  endtask

  // upstream FIFO: byte appears the cycle after a dequeue, empty flag tracks queue
  always @(posedge clk_in) begin
    if (pend && rst_n_in) fifo_data_in = q.pop_front();
    fifo_empty_in = q.size() == 0;
  end

  // frame-timeline model: t counts cycles since the dequeue that began a frame
  always @(negedge clk_in) begin
    if (!rst_n_in) t = -1;
    else if (t < 0 && enable_in && !fifo_empty_in) begin
      t = 0;
      mb = q[0];
    end
    e_tx = 1'b1;
    if (t >= 2) begin
      k = (t - 2) / N;
      e_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : mb[3'(k - 1)];
    end
    chk("dequeue", fifo_dequeue_out, t == 0);
    chk("tx", tx_out, e_tx);
    chk("busy", busy_out, t >= 0);
    chk("done", done_out, t == LAST);
    pend = fifo_dequeue_out;
    if (fifo_dequeue_out) deq_cnt++;
    if (done_out) done_cnt++;
    if (busy_out) busy_cnt++;
    if (!tx_out) lo_cnt++;
    if (done_out) begin
      gap_on = 1'b1;
      gap_n = 0;
    end else if (gap_on) begin
      if (tx_out) gap_n++;
      else begin
        last_gap = gap_n;
        gap_on = 1'b0;
      end
    end
    if (t >= 0) t = (t == LAST) ? -1 : t + 1;
  end

  task automatic clr();
    deq_cnt = 0;
    done_cnt = 0;
    busy_cnt = 0;
    lo_cnt = 0;
    last_gap = -1;
    gap_on = 1'b0;
  endtask

  task automatic push(input byte unsigned b);
    q.push_back(b);
  endtask

  task automatic wait_deq();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (fifo_dequeue_out) break;
    end
    if (i == 50) lit("dequeue_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk_in);
      if (!busy_out && (q.size() == 0 || !enable_in)) break;
    end
    if (i == 2000) lit("idle_timeout", 0, 1);
  endtask

  initial begin
    clr();
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    // single 0xA5 frame, line sampled mid-bit
    clr();
    push(8'hA5);
    enable_in = 1'b1;
    wait_deq();
    @(negedge clk_in);
    for (int i = 0; i < 10; i++) begin
      repeat (i == 0 ? 1 + N / 2 : N) @(negedge clk_in);
      samp[i] = tx_out;
    end
    wait_idle();
    lit("a5_bits", int'(samp), int'(10'b1101001010));
    lit("a5_dequeues", deq_cnt, 1);
    lit("a5_done", done_cnt, 1);
    lit("a5_busy_cycles", busy_cnt, 42);
    // back-to-back 0x00, 0xFF
    @(posedge clk_in);
    #1 clr();
    push(8'h00);
    push(8'hFF);
    repeat (2) @(posedge clk_in);
    wait_idle();
    lit("b2b_dequeues", deq_cnt, 2);
    lit("b2b_done", done_cnt, 2);
    lit("b2b_gap", last_gap, 2);
    lit("b2b_busy_cycles", busy_cnt, 84);
    // empty FIFO, enabled
    @(posedge clk_in);
    #1 clr();
    repeat (100) @(posedge clk_in);
    #1;
    lit("empty_dequeues", deq_cnt, 0);
    lit("empty_low_cycles", lo_cnt, 0);
    lit("empty_busy_cycles", busy_cnt, 0);
    // enable dropped during data bit 3 of 0x3C
    clr();
    push(8'h3C);
    push(8'h81);
    wait_deq();
    repeat (3 + 4 * N) @(negedge clk_in);
    @(posedge clk_in);
    #1 enable_in = 1'b0;
    repeat (60) @(posedge clk_in);
    #1;
    lit("drop_dequeues", deq_cnt, 1);
    lit("drop_done", done_cnt, 1);
    lit("drop_queue_left", q.size(), 1);
    enable_in = 1'b1;
    wait_idle();
    lit("resume_dequeues", deq_cnt, 2);
    lit("resume_done", done_cnt, 2);
    // reset in the middle of a data bit
    @(posedge clk_in);
    #1 clr();
    push(8'h5A);
    wait_deq();
    repeat (2 + 3 * N) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    lit("reset_tx", int'(tx_out), 1);
    lit("reset_busy", int'(busy_out), 0);
    lit("reset_done", int'(done_out), 0);
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    clr();
    repeat (50) @(posedge clk_in);
    #1;
    lit("post_reset_dequeues", deq_cnt, 0);
    lit("post_reset_low_cycles", lo_cnt, 0);
    // randomized traffic, enable toggling and occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk_in);
      #1;
      if ($urandom_range(0, 39) == 0 && q.size() < 8) push(8'($urandom));
      if ($urandom_range(0, 59) == 0) enable_in = ~enable_in;
      if ($urandom_range(0, 1999) == 0) begin
        rst_n_in = 1'b0;
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
      end
    end
    enable_in = 1'b1;
    wait_idle();
    lit("drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
